des_key_sched: RTL and testbench

DES_KEY_SCHED -- requirements
Module: des_key_sched

---
 rtl/des_key_sched.sv | 135 +++++++++++++
 tb/tb_des_key_sched.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_sched.sv
// des_key_sched: DES subkey generator (PC-1, C/D rotations, PC-2) delivering K1..K16 or K16..K1 over valid/ready beats.
// Defining DES_KEY_PARITY_CHECK_EN rejects keys whose bytes lack odd parity and pulses key_err.
module des_key_sched #(
    parameter int KEYS_PER_CYCLE = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        decrypt,
    input  logic [64:1]                 key_in,
    output logic [48*KEYS_PER_CYCLE:1]  subkey_out,
    output logic                        subkey_valid,
    input  logic                        subkey_ready,
    output logic [4:0]                  round_idx,
    output logic                        busy,
    output logic                        done,
    output logic                        key_err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [6:0] PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam logic [5:0] PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    if (KEYS_PER_CYCLE != 1 && KEYS_PER_CYCLE != 2) begin : g_bad_kpc
        $error("des_key_sched: KEYS_PER_CYCLE must be 1 or 2");
    end

    // cd[28:1] holds C (cd[1] = C bit 1), cd[56:29] holds D, so PC-2 indexes cd directly.
    function automatic logic [56:1] pc1(input logic [64:1] k);
        logic [56:1] r;
        for (int i = 1; i <= 56; i++) r[i] = k[PC1[i-1]];
        return r;
    endfunction

    function automatic logic [48:1] pc2(input logic [56:1] cd_v);
        logic [48:1] r;
        for (int i = 1; i <= 48; i++) r[i] = cd_v[PC2[i-1]];
        return r;
    endfunction

    function automatic logic [28:1] rot28(input logic [28:1] x, input logic two, input logic right);
        logic [28:1] y;
        y = right ? {x[27:1], x[28]} : {x[1], x[28:2]};
        return two ? (right ? {y[27:1], y[28]} : {y[1], y[28:2]}) : y;
    endfunction

    function automatic logic [56:1] rot56(input logic [56:1] x, input logic two, input logic right);
        return {rot28(x[56:29], two, right), rot28(x[28:1], two, right)};
    endfunction

    function automatic logic shift2(input logic [4:0] r);
        return !(r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16);
    endfunction

    logic [1:0]  state;
    logic [56:1] cd, cd1, cd2, cd_next;
    logic [4:0]  r_nxt1, r2, r_adv;
    logic        dec, two1, two2, last, fire, key_ok;
    logic [48:1] k1, k2;

`ifdef DES_KEY_PARITY_CHECK_EN
    always_comb begin
        key_ok = 1'b1;
        for (int i = 0; i < 8; i++) key_ok &= ^key_in[8*i+1 +: 8];
    end
`else
    assign key_ok = 1'b1;
`endif

    // cd1 is the state after the current subkey's rotation; cd2 after the following one.
    always_comb begin
        r_nxt1  = (round_idx == 5'd16) ? 5'd1 : round_idx + 5'd1;
        two1    = shift2(dec ? round_idx : r_nxt1);
        cd1     = rot56(cd, two1, dec);
        r2      = dec ? round_idx - 5'd1 : r_nxt1;
        two2    = shift2(dec ? r2 : ((r2 == 5'd16) ? 5'd1 : r2 + 5'd1));
        cd2     = rot56(cd1, two2, dec);
        cd_next = (KEYS_PER_CYCLE == 2) ? cd2 : cd1;
        r_adv   = dec ? round_idx - 5'(KEYS_PER_CYCLE) : round_idx + 5'(KEYS_PER_CYCLE);
        last    = dec ? (round_idx == 5'(KEYS_PER_CYCLE)) : (round_idx == 5'(17 - KEYS_PER_CYCLE));
        fire    = subkey_valid && subkey_ready;
        k1      = pc2(cd);
        k2      = pc2(cd1);
    end

    if (KEYS_PER_CYCLE == 2) begin : g_two
        assign subkey_out = subkey_valid ? {k2, k1} : '0;
    end else begin : g_one
        assign subkey_out = subkey_valid ? k1 : '0;
    end

    assign busy = state != IDLE;
    assign done = state == DONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cd           <= '0;
            dec          <= 1'b0;
            round_idx    <= 5'd0;
            subkey_valid <= 1'b0;
            key_err      <= 1'b0;
        end else begin
            key_err <= 1'b0;
            if (state == IDLE && start && key_ok) begin
                state        <= RUN;
                dec          <= decrypt;
                round_idx    <= decrypt ? 5'd16 : 5'd1;
                cd           <= decrypt ? pc1(key_in) : rot56(pc1(key_in), 1'b0, 1'b0);
                subkey_valid <= 1'b1;
            end else if (state == IDLE && start) begin
                key_err <= 1'b1;
            end else if (state == RUN && fire) begin
                cd        <= cd_next;
                round_idx <= last ? 5'd0 : r_adv;
                if (last) begin
                    subkey_valid <= 1'b0;
                    state        <= DONE;
                end
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_des_key_sched.sv
// tb_des_key_sched: table vectors, corner sequences and random runs for des_key_sched against a textbook DES key-schedule model.
module tb_des_key_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start1, dec1, ready1, v1, busy1, done1, kerr1;
    logic [64:1] key1;
    logic [48:1] sk1;
    logic [4:0]  ri1;
    logic start2, dec2, ready2, v2, busy2, done2, kerr2;
    logic [64:1] key2;
    logic [96:1] sk2;
    logic [4:0]  ri2;

    des_key_sched #(.KEYS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .decrypt(dec1), .key_in(key1),
        .subkey_out(sk1), .subkey_valid(v1), .subkey_ready(ready1), .round_idx(ri1),
        .busy(busy1), .done(done1), .key_err(kerr1));

    des_key_sched #(.KEYS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .decrypt(dec2), .key_in(key2),
        .subkey_out(sk2), .subkey_valid(v2), .subkey_ready(ready2), .round_idx(ri2),
        .busy(busy2), .done(done2), .key_err(kerr2));

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
`ifdef DES_KEY_PARITY_CHECK_EN
    localparam logic [63:0] ZKEY = 64'h0101010101010101;
`else
    localparam logic [63:0] ZKEY = 64'h0000000000000000;
`endif

    int pc1_t [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                       63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    int pc2_t [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                       41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};

    logic [47:0] ks [1:16];
    logic [47:0] f_sk, l_sk, f2_lo, l2_hi;
    logic [4:0]  f_ri, l_ri;
    int n_chk = 0, n_pass = 0;

    typedef struct {
        logic [63:0] key;
        logic        dec;
        logic [47:0] fsk;
        logic [4:0]  fri;
        logic [47:0] lsk;
        logic [4:0]  lri;
    } vec_t;
    vec_t tbl [3];

    // Conventional MSB-first arithmetic: bit position p (1 = MSB) of an n-bit word is word[n-p].
    task automatic ref_model(input logic [63:0] key);
        logic [27:0] c, d;
        logic [55:0] cd;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-pc1_t[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 1; r <= 16; r++) begin
            int s;
            s = (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
            repeat (s) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[r][47-i] = cd[56-pc2_t[i]];
        end
    endtask

    function automatic logic [63:0] rev64(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = x[63-i];
        return r;
    endfunction

    function automatic logic [47:0] rev48(input logic [47:0] x);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[i] = x[47-i];
        return r;
    endfunction

    function automatic logic [63:0] odd_par(input logic [63:0] x);
        logic [63:0] r;
        r = x;
        for (int b = 0; b < 8; b++) r[8*b] = ~^x[8*b+1 +: 7];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run1(input logic [63:0] key, input logic dec, input int stall_beat,
                        input bit rnd, input int abort_at, input bit hold);
        int beat, cyc, stall;
        logic [4:0] er;
        ref_model(key);
        key1 = rev64(key); dec1 = dec; start1 = 1'b1; ready1 = 1'b1;
        @(negedge clk);
        if (hold) key1 = ~key1; else start1 = 1'b0;
        check("kerr1_run", kerr1, 0);
        beat = 0; cyc = 1; stall = 0;
        while (beat < 16 && beat != abort_at && cyc < 400) begin
            check("busy1_run", busy1, 1);
            if (!v1) begin
                check("v1_run", v1, 1);
                break;
            end
            er = dec ? 5'(16 - beat) : 5'(beat + 1);
            check("sk1", rev48(sk1), ks[er]);
            check("ri1", ri1, er);
            if (beat == 0) begin f_sk = rev48(sk1); f_ri = ri1; end
            l_sk = rev48(sk1); l_ri = ri1;
            if (beat + 1 == stall_beat && stall < 5) begin
                ready1 = 1'b0;
                stall++;
            end else ready1 = rnd ? 1'($urandom) : 1'b1;
            if (ready1) beat++;
            @(negedge clk);
            cyc++;
        end
        if (beat == abort_at) return;
        check("beats1", beat, 16);
        check("done1", done1, 1);
        check("v1_done", v1, 0);
        check("sk1_zero", sk1, 0);
        if (!rnd && stall_beat == 0) check("done1_cycle", cyc, 17);
        if (stall_beat != 0) check("done1_cycle_stall", cyc, 22);
        @(negedge clk);
        check("done1_pulse", done1, 0);
        check("busy1_idle", busy1, 0);
        if (hold) begin
            @(negedge clk);
            check("restart_v1", v1, 1);
            check("restart_ri1", ri1, dec ? 16 : 1);
            start1 = 1'b0;
        end
    endtask

    task automatic run2(input logic [63:0] key, input logic dec, input bit rnd);
        int beat, cyc;
        logic [4:0] e1, e2;
        ref_model(key);
        key2 = rev64(key); dec2 = dec; start2 = 1'b1; ready2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        beat = 0; cyc = 1;
        while (beat < 8 && cyc < 200) begin
            if (!v2) begin
                check("v2_run", v2, 1);
                break;
            end
            e1 = dec ? 5'(16 - 2*beat) : 5'(2*beat + 1);
            e2 = dec ? e1 - 5'd1 : e1 + 5'd1;
            check("sk2_lo", rev48(sk2[48:1]), ks[e1]);
            check("sk2_hi", rev48(sk2[96:49]), ks[e2]);
            check("ri2", ri2, e1);
            if (beat == 0) f2_lo = rev48(sk2[48:1]);
            l2_hi = rev48(sk2[96:49]);
            ready2 = rnd ? 1'($urandom) : 1'b1;
            if (ready2) beat++;
            @(negedge clk);
            cyc++;
        end
        check("beats2", beat, 8);
        check("done2", done2, 1);
        check("sk2_zero", {63'd0, |sk2}, 0);
        if (!rnd) check("done2_cycle", cyc, 9);
        @(negedge clk);
        check("done2_pulse", done2, 0);
        check("busy2_idle", busy2, 0);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_v1", v1, 0);
        check("rst_sk1", sk1, 0);
        check("rst_ri1", ri1, 0);
        check("rst_busy1", busy1, 0);
        check("rst_done1", done1, 0);
        @(negedge clk);
        rst = 1'b0; start1 = 1'b0; ready1 = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{KEY,  1'b0, 48'h1B02EFFC7072, 5'd1,  48'hCB3D8B0E17F5, 5'd16};
        tbl[1] = '{KEY,  1'b1, 48'hCB3D8B0E17F5, 5'd16, 48'h1B02EFFC7072, 5'd1};
        tbl[2] = '{ZKEY, 1'b0, 48'h0,            5'd1,  48'h0,            5'd16};
        start1 = 0; dec1 = 0; ready1 = 1; key1 = '0;
        start2 = 0; dec2 = 0; ready2 = 1; key2 = '0;
        repeat (2) @(negedge clk);
        check("por_v1", v1, 0);
        check("por_sk1", sk1, 0);
        check("por_ri1", ri1, 0);
        check("por_busy1", busy1, 0);
        check("por_done1", done1, 0);
        check("por_kerr1", kerr1, 0);
        check("por_v2", v2, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            run1(tbl[i].key, tbl[i].dec, 0, 0, -1, 0);
            check("tbl_first_sk", f_sk, tbl[i].fsk);
            check("tbl_first_ri", f_ri, tbl[i].fri);
            check("tbl_last_sk", l_sk, tbl[i].lsk);
            check("tbl_last_ri", l_ri, tbl[i].lri);
        end

        run1(KEY, 1'b0, 3, 0, -1, 0);
        run1(KEY, 1'b1, 0, 0, -1, 1);
        do_reset();

        run1(KEY, 1'b0, 0, 0, 7, 0);
        do_reset();
        run1(ZKEY, 1'b0, 0, 0, -1, 0);
        check("post_rst_first", f_sk, 48'h0);
        check("post_rst_last", l_sk, 48'h0);

`ifdef DES_KEY_PARITY_CHECK_EN
        key1 = rev64(64'h133457799BBCDFF0); start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("par_kerr", kerr1, 1);
        check("par_busy", busy1, 0);
        check("par_v1", v1, 0);
        @(negedge clk);
        check("par_kerr_pulse", kerr1, 0);
        check("par_busy2", busy1, 0);
        run1(KEY, 1'b0, 0, 0, -1, 0);
`else
        run1(64'h133457799BBCDFF0, 1'b0, 0, 0, -1, 0);
        check("nopar_first", f_sk, 48'h1B02EFFC7072);
        check("nopar_kerr", kerr1, 0);
`endif

        run2(KEY, 1'b0, 0);
        check("kpc2_first_lo", f2_lo, 48'h1B02EFFC7072);
        check("kpc2_last_hi", l2_hi, 48'hCB3D8B0E17F5);
        run2(KEY, 1'b1, 0);
        check("kpc2_dec_first", f2_lo, 48'hCB3D8B0E17F5);
        check("kpc2_dec_last", l2_hi, 48'h1B02EFFC7072);

        for (int i = 0; i < 6; i++)
            run1(odd_par({$urandom, $urandom}), 1'($urandom), 0, 1, -1, 0);
        for (int i = 0; i < 4; i++)
            run2(odd_par({$urandom, $urandom}), 1'($urandom), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
